// File: rtl/dac_spi_driver.sv
// SPI DAC output stage: converts signed demands to offset-binary codes and ships 24-bit frames.
// Optional slew limiting of the code step per frame is enabled with `define SLEW_LIMIT_EN.
module dac_spi_driver #(
    parameter int          CLK_DIV  = 4,
    parameter logic [3:0]  CMD      = 4'b0011,
    parameter logic [3:0]  ADDR     = 4'b0000,
    parameter int          MAX_STEP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] u_in,
    input  logic        u_valid,
    output logic        u_ready,
    input  logic        guardian_in,
    output logic        dac_sclk,
    output logic        dac_cs_n,
    output logic        dac_mosi,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_LDAC
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [4:0]         r_bit, w_bit_nxt;
    logic [15:0]        r_u_in;
    logic               r_guard;
    logic [23:0]        r_frame;
    logic [15:0]        r_last_code;
    logic               r_sclk, r_cs_n, r_mosi, r_ldac_n, r_ready, r_overrun;
    logic [15:0]        r_frame_cnt;
    logic               w_sclk_nxt, w_cs_n_nxt, w_mosi_nxt, w_ldac_n_nxt, w_ready_nxt;
    logic               w_cnt_inc, w_div_last;
    logic [15:0]        w_code, w_sent;
    logic [23:0]        w_frame_new;

    assign w_code      = {~r_u_in[15], r_u_in[14:0]};
    assign w_frame_new = {CMD, ADDR, w_sent};
    assign w_div_last  = (r_div == DIV_W'(CLK_DIV - 1));

`ifdef SLEW_LIMIT_EN
    logic signed [16:0] w_delta, w_delta_lim;
    assign w_delta = $signed({1'b0, w_code}) - $signed({1'b0, r_last_code});

    // Guardian bypasses the clamp so emergency demands reach the DAC immediately.
    always_comb begin
        w_delta_lim = w_delta;
        if (!r_guard) begin
            if (w_delta > $signed(17'(MAX_STEP)))
                w_delta_lim = $signed(17'(MAX_STEP));
            else if (w_delta < -$signed(17'(MAX_STEP)))
                w_delta_lim = -$signed(17'(MAX_STEP));
        end
    end
    assign w_sent = r_last_code + w_delta_lim[15:0];
`else
    logic w_unused_nc;
    assign w_unused_nc = ^{r_guard, r_last_code};
    assign w_sent      = w_code;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_bit_nxt    = r_bit;
        w_sclk_nxt   = r_sclk;
        w_cs_n_nxt   = r_cs_n;
        w_mosi_nxt   = r_mosi;
        w_ldac_n_nxt = r_ldac_n;
        w_ready_nxt  = r_ready;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (u_valid) begin
                    w_state_nxt = S_LOAD;
                    w_ready_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_CS_SETUP;
                w_div_nxt   = '0;
                w_cs_n_nxt  = 1'b0;
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = w_frame_new[23];
            end
            S_CS_SETUP: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_last) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_bit_nxt   = 5'd23;
                end
            end
            S_SHIFT: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else if (r_bit == 5'd0) begin
                        w_state_nxt = S_CS_HOLD;
                        w_sclk_nxt  = 1'b0;
                    end else begin
                        // Data moves on the falling edge so it is stable across the DAC's rising-edge sample.
                        w_sclk_nxt = 1'b0;
                        w_bit_nxt  = r_bit - 5'd1;
                        w_mosi_nxt = r_frame[r_bit - 5'd1];
                    end
                end
            end
            S_CS_HOLD: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_last) begin
                    w_state_nxt  = S_LDAC;
                    w_div_nxt    = '0;
                    w_cs_n_nxt   = 1'b1;
                    w_ldac_n_nxt = 1'b0;
                end
            end
            S_LDAC: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_last) begin
                    w_state_nxt  = S_IDLE;
                    w_div_nxt    = '0;
                    w_ldac_n_nxt = 1'b1;
                    w_ready_nxt  = 1'b1;
                    w_cnt_inc    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_u_in      <= '0;
            r_guard     <= 1'b0;
            r_frame     <= '0;
            r_last_code <= 16'h8000;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_ldac_n    <= 1'b1;
            r_ready     <= 1'b1;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_bit    <= w_bit_nxt;
            r_sclk   <= w_sclk_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_mosi   <= w_mosi_nxt;
            r_ldac_n <= w_ldac_n_nxt;
            r_ready  <= w_ready_nxt;
            if (r_state == S_IDLE && u_valid) begin
                r_u_in  <= u_in;
                r_guard <= guardian_in;
            end
            if (r_state == S_LOAD) begin
                r_frame     <= w_frame_new;
                r_last_code <= w_sent;
            end
            if (w_cnt_inc)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if (u_valid && !r_ready)
                r_overrun <= 1'b1;
        end
    end

    assign u_ready    = r_ready;
    assign busy       = ~r_ready;
    assign dac_sclk   = r_sclk;
    assign dac_cs_n   = r_cs_n;
    assign dac_mosi   = r_mosi;
    assign dac_ldac_n = r_ldac_n;
    assign frame_cnt  = r_frame_cnt;
    assign overrun    = r_overrun;

endmodule
